// File: rtl/pit_multichannel.sv
// rtl/pit_multichannel.sv - multichannel programmable interval timer
// Each channel: down counter with reload, optional prescaler, one-shot/periodic, sticky irq.
module pit_multichannel #(
  parameter int NUM_CH     = 2,
  parameter int COUNT_W    = 16,
  parameter int PRESCALE_W = 8,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [NUM_CH-1:0] irq_ack,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any,
  output logic [NUM_CH-1:0] active
);

  logic [ADDR_W-3:0] ch_sel;
  logic [1:0]        reg_sel;

  assign ch_sel  = wr_addr[ADDR_W-1:2];
  assign reg_sel = wr_addr[1:0];
  assign irq_any = |irq;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                  en;
    logic                  periodic;
    logic                  pse;
    logic [COUNT_W-1:0]    count;
    logic [COUNT_W-1:0]    reload;
    logic [7:0]            staged_lo;
    logic [PRESCALE_W-1:0] p_val;
    logic [PRESCALE_W-1:0] presc;
    logic                  irq_q;
    logic                  hit;
    logic                  ctrl_wr;
    logic                  stop;
    logic                  start;
    logic                  tick;
    logic                  expire;
    logic [15:0]           reload_next;

    always_comb begin
      hit         = wr_en && (ch_sel == (ADDR_W-2)'(i));
      ctrl_wr     = hit && (reg_sel == 2'd0);
      stop        = ctrl_wr && !wr_data[0];
      tick        = en && (!pse || (presc == p_val));
      expire      = tick && (count == '0);
      // A start also covers re-arming a one-shot on the very edge it expires.
      start       = ctrl_wr && wr_data[0] && (!en || (expire && !periodic));
      reload_next = {wr_data, staged_lo};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        en        <= 1'b0;
        periodic  <= 1'b0;
        pse       <= 1'b0;
        count     <= '0;
        reload    <= '0;
        staged_lo <= '0;
        p_val     <= '0;
        presc     <= '0;
        irq_q     <= 1'b0;
      end else begin
        if (expire && !stop) begin
          irq_q <= 1'b1;
        end else if (irq_ack[i]) begin
          irq_q <= 1'b0;
        end

        if (tick && !stop) begin
          if (count != '0) begin
            count <= count - COUNT_W'(1);
          end else if (periodic) begin
            count <= reload;
          end else begin
            en <= 1'b0;
          end
        end

        if (en && pse && !stop) begin
          presc <= (presc == p_val) ? '0 : presc + PRESCALE_W'(1);
        end

        if (hit) begin
          case (reg_sel)
            2'd0: begin
              en       <= wr_data[0];
              periodic <= wr_data[1];
              pse      <= wr_data[2];
              if (start) begin
                count <= reload;
                presc <= '0;
              end
            end
            2'd1:    staged_lo <= wr_data;
            2'd2:    reload    <= reload_next[COUNT_W-1:0];
            default: p_val     <= wr_data[PRESCALE_W-1:0];
          endcase
        end
      end
    end

    assign irq[i]    = irq_q;
    assign active[i] = en;
  end

endmodule

// File: tb/tb_pit_multichannel.sv
// tb/tb_pit_multichannel.sv - self-checking bench for pit_multichannel
// Expected irq rise cycles are queued at stimulus time and consumed by an edge monitor.
module tb_pit_multichannel;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] irq_ack;
  logic [1:0] irq;
  logic       irq_any;
  logic [1:0] active;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int q0[$];
  int q1[$];
  logic [1:0] irq_prev = 2'b00;

  pit_multichannel #(
    .NUM_CH(2), .COUNT_W(16), .PRESCALE_W(8), .ADDR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .irq_ack(irq_ack), .irq(irq), .irq_any(irq_any), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Every irq rising edge must match the next queued expected cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (irq[0] && !irq_prev[0]) begin
        if (q0.size() == 0) chk("irq0_unexpected_rise", cyc, -1);
        else chk("irq0_rise_cycle", cyc, q0.pop_front());
      end
      if (irq[1] && !irq_prev[1]) begin
        if (q1.size() == 0) chk("irq1_unexpected_rise", cyc, -1);
        else chk("irq1_rise_cycle", cyc, q1.pop_front());
      end
    end
    irq_prev = irq;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d, output int eidx);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    eidx = cyc;
  endtask

  task automatic ack(input logic [1:0] m);
    irq_ack = m;
    @(negedge clk);
    irq_ack = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int e, e1, t;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; irq_ack = '0;
    repeat (3) @(negedge clk);
    chk("reset_irq", irq, 0);
    chk("reset_irq_any", irq_any, 0);
    chk("reset_active", active, 0);
    reset = 1'b0;

    // 1: one-shot reload 5
    wr(4'd1, 8'd5, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h01, e);
    q0.push_back(e + 6);
    chk("t1_active_running", active, 2'b01);
    wait_until(e + 5);
    chk("t1_irq_before", irq, 0);
    wait_until(e + 6);
    chk("t1_irq_set", irq, 2'b01);
    chk("t1_active_fell", active, 0);
    ack(2'b01);
    chk("t1_irq_acked", irq, 0);
    idle(20);
    chk("t1_no_more_irq", irq, 0);

    // 2: periodic, reload 3, prescale P=1 -> period 8
    wr(4'd3, 8'd1, t); wr(4'd1, 8'd3, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h07, e);
    q0.push_back(e + 8); q0.push_back(e + 16);
    wait_until(e + 12);
    chk("t2_irq_held", irq, 2'b01);
    ack(2'b01);
    chk("t2_irq_cleared", irq, 0);
    wait_until(e + 15);
    ack(2'b01);
    chk("t2_ack_on_expiry_set_wins", irq, 2'b01);
    wr(4'd0, 8'h00, t);
    ack(2'b01);
    chk("t2_stopped_irq", irq, 0);
    chk("t2_stopped_active", active, 0);

    // 3: two channels concurrently; channel index 2 writes ignored
    wr(4'd1, 8'd2, t); wr(4'd2, 8'd0, t); wr(4'd5, 8'd7, t); wr(4'd6, 8'd0, t);
    wr(4'd8, 8'h03, t); wr(4'd9, 8'hff, t); wr(4'd10, 8'hff, t); wr(4'd11, 8'hff, t);
    chk("t3_ghost_active", active, 0);
    chk("t3_ghost_irq", irq_any, 0);
    wr(4'd0, 8'h01, e); wr(4'd4, 8'h01, e1);
    q0.push_back(e + 3); q1.push_back(e1 + 8);
    chk("t3_both_active", active, 2'b11);
    wait_until(e + 3);
    chk("t3_irq_ch0_only", irq, 2'b01);
    chk("t3_irq_any_ch0", irq_any, 1);
    wait_until(e1 + 8);
    chk("t3_irq_both", irq, 2'b11);
    chk("t3_active_done", active, 0);
    ack(2'b01);
    chk("t3_irq_any_ch1", irq_any, 1);
    ack(2'b10);
    chk("t3_irq_any_clear", irq_any, 0);

    // 4: reload rewritten mid-count takes effect at next reload
    wr(4'd1, 8'd4, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h03, e);
    wr(4'd1, 8'h34, t); wr(4'd2, 8'h12, t);
    q0.push_back(e + 5); q0.push_back(e + 5 + 16'h1235);
    wait_until(e + 5);
    chk("t4_first_period", irq, 2'b01);
    ack(2'b01);
    wait_until(e + 5 + 16'h1234);
    chk("t4_before_second", irq, 0);
    wait_until(e + 5 + 16'h1235);
    chk("t4_second_period", irq, 2'b01);
    wr(4'd0, 8'h00, t);
    ack(2'b01);

    // 5: reload 0 periodic, then stop and restart from a new reload
    wr(4'd1, 8'd0, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h03, e);
    q0.push_back(e + 1);
    wait_until(e + 1);
    chk("t5_first_expiry", irq, 2'b01);
    ack(2'b01);
    chk("t5_every_cycle_a", irq, 2'b01);
    ack(2'b01);
    chk("t5_every_cycle_b", irq, 2'b01);
    wr(4'd0, 8'h00, t);
    ack(2'b01);
    chk("t5_stop_irq", irq, 0);
    idle(3);
    chk("t5_stop_held", irq, 0);
    wr(4'd1, 8'd3, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h01, e);
    q0.push_back(e + 4);
    wait_until(e + 4);
    chk("t5_restart_from_reload", irq, 2'b01);
    ack(2'b01);

    // 6: reset mid-count
    wr(4'd1, 8'd10, t); wr(4'd2, 8'd0, t); wr(4'd0, 8'h01, e);
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_reset_irq", irq, 0);
    chk("t6_reset_active", active, 0);
    chk("t6_reset_irq_any", irq_any, 0);
    idle(20);
    chk("t6_irq_stays_0", irq, 0);
    wr(4'd0, 8'h01, e);
    q0.push_back(e + 1);
    wait_until(e + 1);
    chk("t6_reenable_reload0", irq, 2'b01);
    ack(2'b01);
    idle(2);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
